// File: rtl/fixed_to_fp_seq_if.sv
// Handshake bundle for the fixed-to-float converter: input valid/ready with
// the fixed-point word, and output valid/ready with the float result.
interface fixed_to_fp_seq_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] fixed_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] fp_o;
  logic        busy_o;

  // Producer/consumer side (drives the input word, accepts the result)
  modport master (
    output valid_i, fixed_i, ready_i,
    input  ready_o, valid_o, fp_o, busy_o
  );

  // Converter side
  modport slave (
    input  valid_i, fixed_i, ready_i,
    output ready_o, valid_o, fp_o, busy_o
  );
endinterface

// File: rtl/fixed_to_fp_seq.sv
// Sequential signed fixed-point to IEEE-754 single converter.
// Normalisation shifts by 4 or 1 per cycle to keep the per-cycle logic small,
// then a single round-to-nearest-even step builds the result word.
module fixed_to_fp_seq #(
  parameter int FRAC_BITS = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  fixed_to_fp_seq_if.slave bus
);

  // Exponent of a value whose MSB sits at bit 31 of the magnitude.
  localparam logic [7:0] EXP_INIT = 8'(127 + 31 - FRAC_BITS);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t      state_q;
  logic        ready_q;
  logic        valid_q;
  logic        busy_q;
  logic [31:0] fp_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;

  // Rounding of the normalised magnitude (MSB is the hidden bit).
  logic [22:0] mant_trunc;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [22:0] mant_d;
  logic [7:0]  exp_round_d;
  logic [31:0] mag_abs;

  // Round-to-nearest-even result and absolute value of the incoming word
  always_comb begin
    mant_trunc  = mag_q[30:8];
    guard_bit   = mag_q[7];
    sticky_bit  = |mag_q[6:0];
    round_up    = guard_bit && (sticky_bit || mant_trunc[0]);
    mant_sum    = {1'b0, mant_trunc} + {23'd0, round_up};
    // A carry out of the mantissa means the value rounded up to the next power of two.
    mant_d      = mant_sum[23] ? 23'd0 : mant_sum[22:0];
    exp_round_d = mant_sum[23] ? exp_q + 8'd1 : exp_q;
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    mag_abs     = bus.fixed_i[31] ? (~bus.fixed_i + 32'd1) : bus.fixed_i;
  end

  // Control FSM with registered handshake/status outputs and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      fp_q    <= 32'd0;
      sign_q  <= 1'b0;
      mag_q   <= 32'd0;
      exp_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // ready_q is always high here, so valid_i alone marks an accept.
          if (bus.valid_i) begin
            sign_q  <= bus.fixed_i[31];
            mag_q   <= mag_abs;
            exp_q   <= EXP_INIT;
            ready_q <= 1'b0;
            if (bus.fixed_i == 32'd0) begin
              state_q <= OUT;
              fp_q    <= 32'd0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= NORM;
              busy_q  <= 1'b1;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else if (mag_q[31:28] == 4'd0) begin
            mag_q <= {mag_q[27:0], 4'd0};
            exp_q <= exp_q - 8'd4;
          end else begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          fp_q    <= {sign_q, exp_round_d, mant_d};
          state_q <= OUT;
          valid_q <= 1'b1;
        end
        OUT: begin
          if (bus.ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.fp_o    = fp_q;

endmodule

// File: tb/tb_fixed_to_fp_seq.sv
// Directed and random checks of fixed_to_fp_seq against an arithmetic
// reference conversion (MSB search, divide-style rounding) and the
// expected cycle latency.
module tb_fixed_to_fp_seq;
  localparam int FRAC_BITS = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  fixed_to_fp_seq_if bus ();

  fixed_to_fp_seq #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value = fixed / 2^FRAC_BITS, rounded to 24 significant bits, ties to even.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint mag, q, r, half;
    int p, e;
    logic s;
    if (x == 32'd0) return 32'd0;
    s   = x[31];
    mag = s ? (64'sd4294967296 - longint'(x)) : longint'(x);
    p = 0;
    for (int i = 0; i < 40; i++) if (mag >= (64'sd1 <<< i)) p = i;
    e = 127 + p - FRAC_BITS;
    if (p > 23) begin
      q    = mag >>> (p - 23);
      r    = mag - (q <<< (p - 23));
      half = 64'sd1 <<< (p - 24);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1;
        e = e + 1;
      end
    end else begin
      q = mag <<< (23 - p);
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  // Expected cycles from accept edge to first valid_o.
  function automatic int ref_latency(input logic [31:0] x);
    logic [31:0] m;
    int l;
    if (x == 32'd0) return 1;
    m = x[31] ? (~x + 32'd1) : x;
    l = 0;
    while (!m[31]) begin
      m = m << 1;
      l++;
    end
    return l / 4 + l % 4 + 1 + 2;
  endfunction

  // Offer x, measure latency, check result; output handshake follows if ready_i is high.
  task automatic convert(input logic [31:0] x, input string tag);
    int cyc;
    @(negedge clk_i);
    cyc = 0;
    while (!bus.ready_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_ready_before"}, {31'd0, bus.ready_o}, 32'd1);
    bus.valid_i = 1'b1;
    bus.fixed_i = x;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    bus.fixed_i = $urandom;
    check({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd1);
    cyc = 1;
    while (!bus.valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(ref_latency(x)));
    check({tag, "_fp"}, bus.fp_o, ref_fp(x));
    $display("txn %s in=%h fp=%h latency=%0d", tag, x, bus.fp_o, cyc);
  endtask

  task automatic after_handshake(input string tag);
    @(negedge clk_i);
    check({tag, "_valid_drop"}, {31'd0, bus.valid_o}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.ready_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] held_fp;
    logic [31:0] rnd;
    int seen;

    bus.valid_i = 1'b0;
    bus.fixed_i = 32'd0;
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_fp", bus.fp_o, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    rst_i = 1'b0;

    // Directed values with hand-derived results
    convert(32'h0001_0000, "one");     check("one_const", bus.fp_o, 32'h3F80_0000); after_handshake("one");
    convert(32'hFFFF_0000, "neg_one"); check("neg_one_const", bus.fp_o, 32'hBF80_0000); after_handshake("neg_one");
    convert(32'h8000_0000, "most_neg"); check("most_neg_const", bus.fp_o, 32'hC700_0000); after_handshake("most_neg");
    convert(32'h0000_0000, "zero");    check("zero_const", bus.fp_o, 32'h0000_0000); after_handshake("zero");
    convert(32'h7FFF_FFFF, "carry");   check("carry_const", bus.fp_o, 32'h4700_0000); after_handshake("carry");
    convert(32'h0100_0001, "tie_even"); check("tie_even_const", bus.fp_o, 32'h4380_0000); after_handshake("tie_even");
    convert(32'h0100_0003, "tie_odd"); check("tie_odd_const", bus.fp_o, 32'h4380_0002); after_handshake("tie_odd");

    // Backpressure: result held while downstream stalls and the input side is noisy
    bus.ready_i = 1'b0;
    convert(32'h0003_8000, "bp");
    held_fp = bus.fp_o;
    for (int i = 0; i < 5; i++) begin
      bus.valid_i = i[0] ? 1'b0 : 1'b1;
      bus.fixed_i = $urandom;
      @(negedge clk_i);
      check("bp_fp_hold", bus.fp_o, held_fp);
      check("bp_valid_hold", {31'd0, bus.valid_o}, 32'd1);
      check("bp_ready_low", {31'd0, bus.ready_o}, 32'd0);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    after_handshake("bp");
    @(negedge clk_i);
    check("bp_no_extra", {31'd0, bus.busy_o}, 32'd0);
    $display("txn bp_release fp=%h", held_fp);

    // Reset during normalisation of the slowest input
    @(negedge clk_i);
    bus.valid_i = 1'b1;
    bus.fixed_i = 32'h0000_0001;
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("mid_rst_fp", bus.fp_o, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (bus.valid_o) seen++;
    end
    check("mid_rst_no_pulse", 32'(seen), 32'd0);
    $display("txn mid_reset discarded in=00000001");
    convert(32'h0002_0000, "post_rst"); check("post_rst_const", bus.fp_o, 32'h4000_0000); after_handshake("post_rst");

    // Random magnitudes across the full leading-zero range, both signs, random backpressure
    for (int k = 0; k < 40; k++) begin
      rnd = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rnd = ~rnd + 32'd1;
      bus.ready_i = ($urandom_range(0, 3) != 0);
      convert(rnd, "rand");
      if (!bus.ready_i) begin
        repeat ($urandom_range(1, 3)) @(negedge clk_i);
        check("rand_hold_valid", {31'd0, bus.valid_o}, 32'd1);
        bus.ready_i = 1'b1;
      end
      after_handshake("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
